// File: rtl/pong_scoreboard_if.sv
// rtl/pong_scoreboard_if.sv - game event inputs and display/status outputs of the scoreboard
interface pong_scoreboard_if;
  logic       endofframe;
  logic [1:0] missed;
  logic [1:0] collided;
  logic       score_clr;
  logic [7:0] seven_value;
  logic [3:0] disp_select;
  logic       game_over;
  logic [1:0] winner;
  logic [7:0] rally;

  modport master (
    output endofframe, missed, collided, score_clr,
    input  seven_value, disp_select, game_over, winner, rally
  );

  modport slave (
    input  endofframe, missed, collided, score_clr,
    output seven_value, disp_select, game_over, winner, rally
  );
endinterface

// File: rtl/pong_scoreboard.sv
// rtl/pong_scoreboard.sv - BCD scores, match FSM, rally counter and 4-digit display scan
module pong_scoreboard #(
  parameter logic [6:0] WIN_SCORE      = 7'd11,
  parameter logic [7:0] LOCKOUT_FRAMES = 8'd60,
  parameter int         REFRESH_BITS   = 18
) (
  input  logic clk50M,
  input  logic reset,
  pong_scoreboard_if.slave bus
);

  typedef enum logic [1:0] {PLAY = 2'd0, LOCKOUT = 2'd1, OVER = 2'd2} state_t;

  state_t state, state_nxt;

  logic [1:0] missed_q, collided_q;
  logic       eof_q;
  logic [1:0] miss_ev, hit_ev;
  logic       frame_ev;

  logic [7:0] p0_score, p1_score, p0_nxt, p1_nxt;
  logic [7:0] p0_inc, p1_inc;
  logic [7:0] lock_cnt, lock_nxt;
  logic [7:0] rally_q, rally_nxt;
  logic [1:0] winner_q, winner_nxt;
  logic [1:0] hit_cnt;
  logic [8:0] rally_sum;

  logic [REFRESH_BITS-1:0] scan_cnt;
  logic [1:0] sel;
  logic [3:0] digit;
  logic [3:0] sel_n;
  logic       dp_on;
  logic [7:0] seg_code;
  logic [7:0] seven_q;
  logic [3:0] disp_q;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bcd_bin(input logic [7:0] v);
    return ({3'b000, v[7:4]} * 7'd10) + {3'b000, v[3:0]};
  endfunction

  function automatic logic [7:0] seg_lut(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Event pulses are registered so every downstream decision sees a clean one-cycle strobe.
  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      missed_q   <= 2'b00;
      collided_q <= 2'b00;
      eof_q      <= 1'b0;
      miss_ev    <= 2'b00;
      hit_ev     <= 2'b00;
      frame_ev   <= 1'b0;
    end else begin
      missed_q   <= bus.missed;
      collided_q <= bus.collided;
      eof_q      <= bus.endofframe;
      miss_ev    <= bus.missed & ~missed_q;
      hit_ev     <= bus.collided & ~collided_q;
      frame_ev   <= bus.endofframe & ~eof_q;
    end
  end

  assign p0_inc    = bcd_inc(p0_score);
  assign p1_inc    = bcd_inc(p1_score);
  assign hit_cnt   = {1'b0, hit_ev[0]} + {1'b0, hit_ev[1]};
  assign rally_sum = {1'b0, rally_q} + {7'b0, hit_cnt};

  always_comb begin
    state_nxt  = state;
    p0_nxt     = p0_score;
    p1_nxt     = p1_score;
    lock_nxt   = lock_cnt;
    winner_nxt = winner_q;
    rally_nxt  = rally_q;

    if (miss_ev == 2'b00 && hit_cnt != 2'd0)
      rally_nxt = rally_sum[8] ? 8'hFF : rally_sum[7:0];

    case (state)
      PLAY: begin
        if (miss_ev == 2'b11) begin
          state_nxt = LOCKOUT;
          lock_nxt  = LOCKOUT_FRAMES;
        end else if (miss_ev[1]) begin
          p0_nxt    = p0_inc;
          rally_nxt = 8'd0;
          if (bcd_bin(p0_inc) == WIN_SCORE) begin
            state_nxt  = OVER;
            winner_nxt = 2'b01;
          end else begin
            state_nxt = LOCKOUT;
            lock_nxt  = LOCKOUT_FRAMES;
          end
        end else if (miss_ev[0]) begin
          p1_nxt    = p1_inc;
          rally_nxt = 8'd0;
          if (bcd_bin(p1_inc) == WIN_SCORE) begin
            state_nxt  = OVER;
            winner_nxt = 2'b10;
          end else begin
            state_nxt = LOCKOUT;
            lock_nxt  = LOCKOUT_FRAMES;
          end
        end
      end
      LOCKOUT: begin
        if (lock_cnt == 8'd0)
          state_nxt = PLAY;
        else if (frame_ev)
          lock_nxt = lock_cnt - 8'd1;
      end
      OVER: begin
        state_nxt = OVER;
      end
      default: begin
        state_nxt = PLAY;
      end
    endcase

    if (bus.score_clr) begin
      state_nxt  = PLAY;
      p0_nxt     = 8'h00;
      p1_nxt     = 8'h00;
      lock_nxt   = 8'd0;
      winner_nxt = 2'b00;
      rally_nxt  = 8'd0;
    end
  end

  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      state    <= PLAY;
      p0_score <= 8'h00;
      p1_score <= 8'h00;
      lock_cnt <= 8'd0;
      winner_q <= 2'b00;
      rally_q  <= 8'd0;
    end else begin
      state    <= state_nxt;
      p0_score <= p0_nxt;
      p1_score <= p1_nxt;
      lock_cnt <= lock_nxt;
      winner_q <= winner_nxt;
      rally_q  <= rally_nxt;
    end
  end

  assign sel = scan_cnt[REFRESH_BITS-1 -: 2];

  always_comb begin
    digit = p1_score[3:0];
    sel_n = 4'b1110;
    dp_on = 1'b0;
    case (sel)
      2'd0: begin digit = p1_score[3:0]; sel_n = 4'b1110; dp_on = (state == OVER) && winner_q[1]; end
      2'd1: begin digit = p1_score[7:4]; sel_n = 4'b1101; end
      2'd2: begin digit = p0_score[3:0]; sel_n = 4'b1011; dp_on = (state == OVER) && winner_q[0]; end
      2'd3: begin digit = p0_score[7:4]; sel_n = 4'b0111; end
      default: begin digit = 4'hF; sel_n = 4'b1111; end
    endcase
  end

  assign seg_code = seg_lut(digit);

  // Display outputs are registered so digit switches never glitch the segments.
  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      seven_q  <= 8'hFF;
      disp_q   <= 4'b1111;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      seven_q  <= dp_on ? (seg_code & 8'h7F) : seg_code;
      disp_q   <= sel_n;
    end
  end

  assign bus.seven_value = seven_q;
  assign bus.disp_select = disp_q;
  assign bus.game_over   = (state == OVER);
  assign bus.winner      = winner_q;
  assign bus.rally       = rally_q;

endmodule
